// File: rtl/i2c_ball_pkg.sv
`default_nettype none
// ============================================================================
// Module      : i2c_ball_pkg
// Description : Shared constants for the ball hand-over I2C slave receiver:
//               FSM state encodings, default slave address, packet byte
//               indices and the expected byte count.
//               Optional feature macro: I2C_RX_CHECKSUM_EN (adds XOR byte B5).
// Revision    : 1.0 - initial release
// ============================================================================
package i2c_ball_pkg;

  typedef logic [2:0] state_t;

  // Receiver FSM states
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_ADDR     = 3'd1;
  localparam logic [2:0] ST_ADDR_ACK = 3'd2;
  localparam logic [2:0] ST_DATA     = 3'd3;
  localparam logic [2:0] ST_DATA_ACK = 3'd4;
  localparam logic [2:0] ST_IGNORE   = 3'd5;

  // Default 7-bit bus address of the ball receiver
  localparam logic [6:0] I2C_BALL_ADDR = 7'h12;

  // Position of each field inside the data phase of a packet
  localparam logic [2:0] IDX_Y_HI  = 3'd0;
  localparam logic [2:0] IDX_Y_LO  = 3'd1;
  localparam logic [2:0] IDX_VY    = 3'd2;
  localparam logic [2:0] IDX_GRAV  = 3'd3;
  localparam logic [2:0] IDX_SPEED = 3'd4;
  localparam logic [2:0] IDX_CSUM  = 3'd5;

  // Number of data bytes a complete packet carries
`ifdef I2C_RX_CHECKSUM_EN
  localparam logic [2:0] BYTE_CNT_EXP = 3'd6;
`else
  localparam logic [2:0] BYTE_CNT_EXP = 3'd5;
`endif

endpackage
`default_nettype wire

// File: rtl/i2c_line_sync.sv
`default_nettype none
// ============================================================================
// Module      : i2c_line_sync
// Description : Synchronizes raw SCL/SDA into the clk domain and produces
//               registered single-cycle SCL edge and START/STOP pulses.
//               sda_s is time-aligned with the event pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic scl,
  input  logic sda,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic                   r_scl_prev;
  logic                   r_sda_prev;
  logic                   w_scl;
  logic                   w_sda;

  assign w_scl = r_scl_sync[SYNC_STAGES-1];
  assign w_sda = r_sda_sync[SYNC_STAGES-1];

  // Synchronizer chains and edge/condition pulse generation; idle bus is high
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_prev <= 1'b1;
      r_sda_prev <= 1'b1;
      sda_s      <= 1'b1;
      scl_rise   <= 1'b0;
      scl_fall   <= 1'b0;
      start_det  <= 1'b0;
      stop_det   <= 1'b0;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda};
      r_scl_prev <= w_scl;
      r_sda_prev <= w_sda;
      sda_s      <= w_sda;
      scl_rise   <= w_scl & ~r_scl_prev;
      scl_fall   <= ~w_scl & r_scl_prev;
      // SDA transitions only count as START/STOP while SCL is steadily high
      start_det  <= r_sda_prev & ~w_sda & w_scl & r_scl_prev;
      stop_det   <= ~r_sda_prev & w_sda & w_scl & r_scl_prev;
    end
  end

endmodule
`default_nettype wire

// File: rtl/i2c_ball_slave_rx.sv
`default_nettype none
// ============================================================================
// Module      : i2c_ball_slave_rx
// Description : Write-only I2C slave that receives the fixed-length ball
//               hand-over packet, ACKs each byte and presents the payload
//               with a one-cycle packet_valid strobe (frame_err on discard).
//               Optional feature macro: I2C_RX_CHECKSUM_EN (XOR check byte).
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_ball_slave_rx
  import i2c_ball_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = I2C_BALL_ADDR,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       SCL,
  inout  wire        SDA,
  output logic [9:0] ball_y,
  output logic [7:0] ball_vy,
  output logic [1:0] gravity_counter,
  output logic [7:0] safe_speed,
  output logic       packet_valid,
  output logic       frame_err,
  output logic       rx_busy
);

  logic       w_sda;
  logic       w_scl_rise;
  logic       w_scl_fall;
  logic       w_start;
  logic       w_stop;
  logic       w_pkt_ok;

  state_t     r_state;
  logic [3:0] r_bit_cnt;
  logic [7:0] r_shift;
  logic [2:0] r_byte_cnt;
  logic       r_addressed;
  logic       r_overflow;
  logic       r_sda_oe;

  // Staging copy of the payload, published only on a clean STOP
  logic [9:0] r_stg_y;
  logic [7:0] r_stg_vy;
  logic [1:0] r_stg_gc;
  logic [7:0] r_stg_ss;

  // Open-drain: only ever pull low or release
  assign SDA     = r_sda_oe ? 1'b0 : 1'bz;
  assign rx_busy = r_addressed;

  i2c_line_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_line_sync (
    .clk       (clk),
    .reset     (reset),
    .scl       (SCL),
    .sda       (SDA),
    .sda_s     (w_sda),
    .scl_rise  (w_scl_rise),
    .scl_fall  (w_scl_fall),
    .start_det (w_start),
    .stop_det  (w_stop)
  );

`ifdef I2C_RX_CHECKSUM_EN
  logic [7:0] r_csum;

  // Running XOR of every stored byte; a correct check byte cancels to zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_csum <= 8'h00;
    end else if (w_stop || w_start) begin
      r_csum <= 8'h00;
    end else if (r_state == ST_DATA && w_scl_fall && r_bit_cnt == 4'd8 &&
                 r_byte_cnt < BYTE_CNT_EXP) begin
      r_csum <= r_csum ^ r_shift;
    end
  end

  assign w_pkt_ok = (r_byte_cnt == BYTE_CNT_EXP) && !r_overflow && (r_csum == 8'h00);
`else
  assign w_pkt_ok = (r_byte_cnt == BYTE_CNT_EXP) && !r_overflow;
`endif

  // Protocol FSM: address match, bit shifting, ACK drive and deframing
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= ST_IDLE;
      r_bit_cnt       <= 4'd0;
      r_shift         <= 8'h00;
      r_byte_cnt      <= 3'd0;
      r_addressed     <= 1'b0;
      r_overflow      <= 1'b0;
      r_sda_oe        <= 1'b0;
      r_stg_y         <= 10'd0;
      r_stg_vy        <= 8'd0;
      r_stg_gc        <= 2'd0;
      r_stg_ss        <= 8'd0;
      ball_y          <= 10'd0;
      ball_vy         <= 8'd0;
      gravity_counter <= 2'd0;
      safe_speed      <= 8'd0;
      packet_valid    <= 1'b0;
      frame_err       <= 1'b0;
    end else begin
      packet_valid <= 1'b0;
      frame_err    <= 1'b0;

      if (w_stop) begin
        r_state     <= ST_IDLE;
        r_bit_cnt   <= 4'd0;
        r_byte_cnt  <= 3'd0;
        r_addressed <= 1'b0;
        r_overflow  <= 1'b0;
        r_sda_oe    <= 1'b0;
        if (r_addressed) begin
          if (w_pkt_ok) begin
            ball_y          <= r_stg_y;
            ball_vy         <= r_stg_vy;
            gravity_counter <= r_stg_gc;
            safe_speed      <= r_stg_ss;
            packet_valid    <= 1'b1;
          end else begin
            frame_err <= 1'b1;
          end
        end
      end else if (w_start) begin
        // Plain or repeated START: any partial packet is abandoned
        r_state     <= ST_ADDR;
        r_bit_cnt   <= 4'd0;
        r_byte_cnt  <= 3'd0;
        r_addressed <= 1'b0;
        r_overflow  <= 1'b0;
        r_sda_oe    <= 1'b0;
        frame_err   <= r_addressed;
      end else begin
        case (r_state)
          ST_ADDR: begin
            if (w_scl_rise && r_bit_cnt != 4'd8) begin
              r_shift   <= {r_shift[6:0], w_sda};
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end else if (w_scl_fall && r_bit_cnt == 4'd8) begin
              r_bit_cnt <= 4'd0;
              if (r_shift == {SLAVE_ADDR, 1'b0}) begin
                r_state     <= ST_ADDR_ACK;
                r_sda_oe    <= 1'b1;
                r_addressed <= 1'b1;
              end else begin
                r_state <= ST_IGNORE;
              end
            end
          end

          ST_ADDR_ACK, ST_DATA_ACK: begin
            // Hold (or withhold) the ACK through the 9th clock
            if (w_scl_fall) begin
              r_sda_oe  <= 1'b0;
              r_bit_cnt <= 4'd0;
              r_state   <= ST_DATA;
            end
          end

          ST_DATA: begin
            if (w_scl_rise && r_bit_cnt != 4'd8) begin
              r_shift   <= {r_shift[6:0], w_sda};
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end else if (w_scl_fall && r_bit_cnt == 4'd8) begin
              r_bit_cnt <= 4'd0;
              r_state   <= ST_DATA_ACK;
              if (r_byte_cnt < BYTE_CNT_EXP) begin
                r_byte_cnt <= r_byte_cnt + 3'd1;
                r_sda_oe   <= 1'b1;
                case (r_byte_cnt)
                  IDX_Y_HI:  r_stg_y[9:8] <= r_shift[1:0];
                  IDX_Y_LO:  r_stg_y[7:0] <= r_shift;
                  IDX_VY:    r_stg_vy     <= r_shift;
                  IDX_GRAV:  r_stg_gc     <= r_shift[1:0];
                  IDX_SPEED: r_stg_ss     <= r_shift;
                  default:   ;
                endcase
              end else begin
                r_overflow <= 1'b1;
              end
            end
          end

          ST_IDLE, ST_IGNORE: ;

          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i2c_ball_slave_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2c_ball_slave_rx
// Description : Self-checking bench for i2c_ball_slave_rx. A bit-banged I2C
//               master drives packets; expected strobes/payloads are queued
//               on a scoreboard and compared when the DUT pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_ball_slave_rx;

  localparam int  SYNC = 2;
  localparam time TQ   = 250ns;
`ifdef I2C_RX_CHECKSUM_EN
  localparam int  EXP_BYTES = 6;
`else
  localparam int  EXP_BYTES = 5;
`endif

  logic       clk;
  logic       reset;
  logic       scl;
  logic       m_sda_low;
  wire        sda;
  logic [9:0] ball_y;
  logic [7:0] ball_vy;
  logic [1:0] gravity_counter;
  logic [7:0] safe_speed;
  logic       packet_valid;
  logic       frame_err;
  logic       rx_busy;

  pullup (sda);
  assign sda = m_sda_low ? 1'b0 : 1'bz;

  i2c_ball_slave_rx #(
    .SLAVE_ADDR  (7'h12),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .SCL             (scl),
    .SDA             (sda),
    .ball_y          (ball_y),
    .ball_vy         (ball_vy),
    .gravity_counter (gravity_counter),
    .safe_speed      (safe_speed),
    .packet_valid    (packet_valid),
    .frame_err       (frame_err),
    .rx_busy         (rx_busy)
  );

  initial clk = 1'b0;
  always #5ns clk = ~clk;

  typedef struct {
    logic       is_valid;
    logic [9:0] y;
    logic [7:0] vy;
    logic [1:0] gc;
    logic [7:0] ss;
  } exp_t;

  exp_t       sb_q[$];
  int         n_checks;
  int         n_fail;
  logic [9:0] m_y;
  logic [7:0] m_vy;
  logic [1:0] m_gc;
  logic [7:0] m_ss;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_valid(input logic [9:0] y, input logic [7:0] vy,
                            input logic [1:0] gc, input logic [7:0] ss);
    exp_t e;
    e.is_valid = 1'b1; e.y = y; e.vy = vy; e.gc = gc; e.ss = ss;
    sb_q.push_back(e);
    m_y = y; m_vy = vy; m_gc = gc; m_ss = ss;
  endtask

  task automatic push_err();
    exp_t e;
    e.is_valid = 1'b0; e.y = m_y; e.vy = m_vy; e.gc = m_gc; e.ss = m_ss;
    sb_q.push_back(e);
  endtask

  // Scoreboard: every strobe must match the oldest queued expectation
  always @(negedge clk) begin
    if (packet_valid || frame_err) begin
      if (sb_q.size() == 0) begin
        check_val("unexpected_pulse", 32'({packet_valid, frame_err}), 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check_val("pulse_kind", 32'({packet_valid, frame_err}), e.is_valid ? 32'd2 : 32'd1);
        check_val("ball_y", 32'(ball_y), 32'(e.y));
        check_val("ball_vy", 32'(ball_vy), 32'(e.vy));
        check_val("gravity_counter", 32'(gravity_counter), 32'(e.gc));
        check_val("safe_speed", 32'(safe_speed), 32'(e.ss));
      end
    end
  end

  task automatic i2c_start();
    m_sda_low = 1'b0; #TQ;
    scl = 1'b1;       #TQ;
    m_sda_low = 1'b1; #TQ;
    scl = 1'b0;       #TQ;
  endtask

  // STOP, then check the strobe lands exactly SYNC+2 clocks after SDA rises
  task automatic i2c_stop(input logic exp_pulse);
    m_sda_low = 1'b1; #TQ;
    scl = 1'b1;       #TQ;
    m_sda_low = 1'b0;
    repeat (SYNC + 1) @(posedge clk);
    #1;
    check_val("stop_pulse_early", 32'(packet_valid | frame_err), 32'd0);
    @(posedge clk);
    #1;
    check_val("stop_pulse", 32'(packet_valid | frame_err), 32'(exp_pulse));
    #TQ;
  endtask

  task automatic send_bits(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      m_sda_low = ~b[i]; #TQ;
      scl = 1'b1;        #TQ; #TQ;
      scl = 1'b0;        #TQ;
    end
    m_sda_low = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] b, input logic exp_ack, input string tag);
    send_bits(b);
    #TQ;
    scl = 1'b1; #TQ;
    check_val(tag, 32'(sda == 1'b0), 32'(exp_ack));
    #TQ;
    scl = 1'b0; #TQ;
  endtask

  // START + address + first n_send data bytes of the packet (no STOP)
  task automatic send_packet(input logic [6:0] addr, input logic [9:0] y, input logic [7:0] vy,
                             input logic [1:0] gc, input logic [7:0] ss,
                             input int n_send, input logic bad_csum);
    logic [7:0] bl [8];
    logic       addr_ok;
    bl[0] = {6'd0, y[9:8]};
    bl[1] = y[7:0];
    bl[2] = vy;
    bl[3] = {6'd0, gc};
    bl[4] = ss;
    bl[5] = 8'hA5;
    bl[6] = 8'h5A;
    bl[7] = 8'h3C;
`ifdef I2C_RX_CHECKSUM_EN
    bl[5] = bl[0] ^ bl[1] ^ bl[2] ^ bl[3] ^ bl[4];
    if (bad_csum) bl[5] = ~bl[5];
`else
    if (bad_csum) bl[5] = 8'h00;
`endif
    addr_ok = (addr == 7'h12);
    i2c_start();
    write_byte({addr, 1'b0}, addr_ok, "addr_ack");
    check_val("rx_busy", 32'(rx_busy), 32'(addr_ok));
    if (addr_ok) begin
      for (int i = 0; i < n_send; i++)
        write_byte(bl[i], (i < EXP_BYTES), "data_ack");
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    m_y = '0; m_vy = '0; m_gc = '0; m_ss = '0;
    scl       = 1'b1;
    m_sda_low = 1'b0;
    reset     = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_val("rst_ball_y", 32'(ball_y), 32'd0);
    check_val("rst_ball_vy", 32'(ball_vy), 32'd0);
    check_val("rst_gravity", 32'(gravity_counter), 32'd0);
    check_val("rst_speed", 32'(safe_speed), 32'd0);
    check_val("rst_valid", 32'(packet_valid), 32'd0);
    check_val("rst_frame_err", 32'(frame_err), 32'd0);
    check_val("rst_rx_busy", 32'(rx_busy), 32'd0);
    check_val("rst_sda", 32'(sda), 32'd1);
    reset = 1'b0;
    #TQ;

    // Nominal packet: 01,2C,F6,02,05
    send_packet(7'h12, 10'h12C, 8'hF6, 2'd2, 8'h05, EXP_BYTES, 1'b0);
    push_valid(10'h12C, 8'hF6, 2'd2, 8'h05);
    i2c_stop(1'b1);

    // Foreign address: NACK, no strobes, outputs untouched
    send_packet(7'h13, 10'h3FF, 8'h11, 2'd1, 8'h22, EXP_BYTES, 1'b0);
    i2c_stop(1'b0);
    check_val("hold_after_nack", 32'(ball_y), 32'h12C);

    // Partial packet cut by repeated START, then a full packet
    send_packet(7'h12, 10'h2AB, 8'h77, 2'd3, 8'h99, 3, 1'b0);
    push_err();
    send_packet(7'h12, 10'h3FF, 8'h0A, 2'd1, 8'hC8, EXP_BYTES, 1'b0);
    push_valid(10'h3FF, 8'h0A, 2'd1, 8'hC8);
    i2c_stop(1'b1);

    // One byte too many: last byte NACKed, packet discarded
    send_packet(7'h12, 10'h001, 8'h02, 2'd0, 8'h03, EXP_BYTES + 1, 1'b0);
    push_err();
    i2c_stop(1'b1);

    // Reset while the slave is ACKing B2
    send_packet(7'h12, 10'h155, 8'h66, 2'd2, 8'h44, 2, 1'b0);
    send_bits(8'h66);
    #TQ;
    scl = 1'b1; #TQ;
    check_val("ack_before_reset", 32'(sda), 32'd0);
    reset = 1'b1;
    #1;
    check_val("reset_sda_release", 32'(sda), 32'd1);
    check_val("reset_ball_y", 32'(ball_y), 32'd0);
    check_val("reset_speed", 32'(safe_speed), 32'd0);
    check_val("reset_rx_busy", 32'(rx_busy), 32'd0);
    m_y = '0; m_vy = '0; m_gc = '0; m_ss = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    #TQ;
    scl = 1'b0; #TQ;
    i2c_stop(1'b0);
    send_packet(7'h12, 10'h0C3, 8'h81, 2'd3, 8'h7E, EXP_BYTES, 1'b0);
    push_valid(10'h0C3, 8'h81, 2'd3, 8'h7E);
    i2c_stop(1'b1);

`ifdef I2C_RX_CHECKSUM_EN
    send_packet(7'h12, 10'h12C, 8'hF6, 2'd2, 8'h05, EXP_BYTES, 1'b1);
    push_err();
    i2c_stop(1'b1);
    send_packet(7'h12, 10'h12C, 8'hF6, 2'd2, 8'h05, EXP_BYTES, 1'b0);
    push_valid(10'h12C, 8'hF6, 2'd2, 8'h05);
    i2c_stop(1'b1);
`endif

    repeat (50) @(posedge clk);
    #1;
    check_val("sb_drain", 32'(sb_q.size()), 32'd0);
    check_val("final_ball_y", 32'(ball_y), 32'(m_y));
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
